// File: rtl/chunk_pkg.sv
// Shared constants and helpers for the chunk-stream blocks: default geometry,
// length-field sizing and normalisation of a requested chunk count.
package chunk_pkg;

  localparam int DEF_CHUNK_BITS = 4;
  localparam int DEF_NUM_CHUNKS = 8;

  // Width needed to encode a chunk count in the range 0..num_chunks.
  function automatic int len_bits(input int num_chunks);
    return $clog2(num_chunks + 1);
  endfunction

  // A request of 0 means a full word; anything larger than a word is clamped.
  function automatic int norm_len(input int len, input int num_chunks);
    if (len == 0 || len > num_chunks) begin
      return num_chunks;
    end
    return len;
  endfunction

endpackage

// File: rtl/chunk_select.sv
// Combinational chunk mux: picks one CHUNK_BITS-wide slice of a word by
// emission index, counting from the low or high end of the word.
module chunk_select
  import chunk_pkg::*;
#(
  parameter int CHUNK_BITS = DEF_CHUNK_BITS,
  parameter int NUM_CHUNKS = DEF_NUM_CHUNKS,
  parameter int MSB_FIRST  = 0,
  parameter int IDX_BITS   = len_bits(DEF_NUM_CHUNKS)
) (
  input  logic [NUM_CHUNKS*CHUNK_BITS-1:0] data,
  input  logic [IDX_BITS-1:0]              index,
  output logic [CHUNK_BITS-1:0]            chunk
);

  logic [IDX_BITS-1:0] sel;

  // MSB-first walks down from the top chunk, so short words send their top chunks.
  always_comb begin
    if (MSB_FIRST != 0) begin
      sel = IDX_BITS'(NUM_CHUNKS - 1) - index;
    end else begin
      sel = index;
    end
  end

  always_comb begin
    chunk = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (sel == IDX_BITS'(k)) begin
        chunk = data[k*CHUNK_BITS +: CHUNK_BITS];
      end
    end
  end

endmodule

// File: rtl/chunk_serializer.sv
// Word-to-chunk serializer with an ACTIVE slot being emitted and a PENDING
// slot that lets the next word start on the cycle after the current one retires.
module chunk_serializer
  import chunk_pkg::*;
#(
  parameter int CHUNK_BITS  = DEF_CHUNK_BITS,
  parameter int NUM_CHUNKS  = DEF_NUM_CHUNKS,
  parameter int MSB_FIRST   = 0,
  localparam int DATA_BITS  = NUM_CHUNKS * CHUNK_BITS,
  localparam int LEN_BITS   = len_bits(NUM_CHUNKS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_BITS-1:0]  in_data,
  input  logic [LEN_BITS-1:0]   in_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHUNK_BITS-1:0] out_bits,
  output logic                  out_last
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // valid never depends on ready; once raised, valid and payload hold until
  // the transfer. in_ready depends only on registered state.

  logic                 act_valid;
  logic [DATA_BITS-1:0] act_data;
  logic [LEN_BITS-1:0]  act_len;
  logic [LEN_BITS-1:0]  index;

  logic                 pend_valid;
  logic [DATA_BITS-1:0] pend_data;
  logic [LEN_BITS-1:0]  pend_len;

  logic                  accept;
  logic                  fire;
  logic                  at_last;
  logic                  retire;
  logic                  to_active;
  logic [LEN_BITS-1:0]   in_len_norm;
  logic [CHUNK_BITS-1:0] sel_chunk;

  assign in_ready    = !pend_valid;
  assign accept      = in_valid && in_ready;
  assign fire        = act_valid && out_ready;
  assign at_last     = act_valid && (index == act_len - LEN_BITS'(1));
  assign retire      = fire && at_last;
  assign to_active   = !act_valid || (retire && !pend_valid);
  assign in_len_norm = LEN_BITS'(norm_len(int'(in_len), NUM_CHUNKS));

  chunk_select #(
    .CHUNK_BITS (CHUNK_BITS),
    .NUM_CHUNKS (NUM_CHUNKS),
    .MSB_FIRST  (MSB_FIRST),
    .IDX_BITS   (LEN_BITS)
  ) u_select (
    .data  (act_data),
    .index (index),
    .chunk (sel_chunk)
  );

  assign out_valid = act_valid;
  assign out_last  = at_last;
  assign out_bits  = act_valid ? sel_chunk : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_valid  <= 1'b0;
      act_data   <= '0;
      act_len    <= '0;
      index      <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_len   <= '0;
    end else begin
      if (fire) begin
        if (at_last) begin
          if (pend_valid) begin
            act_data   <= pend_data;
            act_len    <= pend_len;
            index      <= '0;
            pend_valid <= 1'b0;
          end else begin
            act_valid <= 1'b0;
          end
        end else begin
          index <= index + LEN_BITS'(1);
        end
      end

      // Accept implies PENDING is empty, so this never collides with the
      // PENDING-to-ACTIVE move above; its ACTIVE writes take priority.
      if (accept) begin
        if (to_active) begin
          act_valid <= 1'b1;
          act_data  <= in_data;
          act_len   <= in_len_norm;
          index     <= '0;
        end else begin
          pend_valid <= 1'b1;
          pend_data  <= in_data;
          pend_len   <= in_len_norm;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunk_serializer.sv
// Directed bench for chunk_serializer: an LSB-first default instance plus an
// MSB-first instance, with hand-computed chunk sequences in scoreboard queues.
module tb_chunk_serializer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  in_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_bits;
  logic        out_last;

  logic        m_in_valid = 1'b0;
  logic        m_in_ready;
  logic [31:0] m_in_data = '0;
  logic [3:0]  m_in_len = '0;
  logic        m_out_valid;
  logic        m_out_ready = 1'b1;
  logic [3:0]  m_out_bits;
  logic        m_out_last;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int m_xfer_cnt = 0;

  logic [4:0] exp_q[$];
  logic [4:0] exp_m_q[$];

  logic       hold_active = 1'b0;
  logic [4:0] held = '0;

  // clock / reset
  always #5 clk = ~clk;

  chunk_serializer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_last  (out_last)
  );

  chunk_serializer #(.MSB_FIRST(1)) dut_m (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .in_data   (m_in_data),
    .in_len    (m_in_len),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .out_bits  (m_out_bits),
    .out_last  (m_out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard monitors: sample half a cycle away from the active edge
  always @(negedge clk) begin
    logic [4:0] e;
    if (!reset_n) begin
      hold_active = 1'b0;
    end else begin
      if (out_valid && hold_active) begin
        check("stall_stable", 32'({out_last, out_bits}), 32'(held));
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bx;
        check("chunk", 32'({out_last, out_bits}), 32'(e));
      end
      hold_active = out_valid && !out_ready;
      held        = {out_last, out_bits};
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (reset_n && m_out_valid && m_out_ready) begin
      m_xfer_cnt++;
      e = (exp_m_q.size() > 0) ? exp_m_q.pop_front() : 5'bx;
      check("msb_chunk", 32'({m_out_last, m_out_bits}), 32'(e));
    end
  end

  // driver tasks
  task automatic push(input logic last, input logic [3:0] b);
    exp_q.push_back({last, b});
  endtask

  task automatic offer(input logic [31:0] d, input logic [3:0] len);
    in_valid = 1'b1;
    in_data  = d;
    in_len   = len;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("offer_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  // toggle=1 drives out_ready 1,0,0 repeating from the second cycle on
  task automatic drain(input logic toggle, output int cycles, output int low);
    cycles = 0;
    low    = 0;
    while (exp_q.size() > 0 && cycles < 500) begin
      @(negedge clk);
      if (!in_ready) low++;
      @(posedge clk);
      #1;
      cycles++;
      if (toggle) out_ready = (cycles % 3 == 0);
    end
    if (cycles >= 500) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    int low;
    logic [3:0] seq1[8];
    seq1 = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hd, 4'hc, 4'hb, 4'ha};

    // reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_bits", 32'(out_bits), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // full word LSB-first, len 0 means 8 chunks
    for (int i = 0; i < 8; i++) push(i == 7, seq1[i]);
    xfer_cnt = 0;
    offer(32'habcd1234, 4'd0);
    check("latency_valid", 32'(out_valid), 32'd1);
    drain(1'b0, cyc, low);
    check("t1_cycles", 32'(cyc), 32'd8);
    check("t1_idle", 32'(out_valid), 32'd0);
    check("t1_count", 32'(xfer_cnt), 32'd8);

    // MSB-first instance, len 3 sends top three chunks
    exp_m_q.push_back({1'b0, 4'ha});
    exp_m_q.push_back({1'b0, 4'hb});
    exp_m_q.push_back({1'b1, 4'hc});
    check("m_in_ready", 32'(m_in_ready), 32'd1);
    m_in_valid = 1'b1;
    m_in_data  = 32'habcd1234;
    m_in_len   = 4'd3;
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    cyc = 0;
    while (exp_m_q.size() > 0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("m_cycles", 32'(cyc), 32'd3);
    check("m_idle", 32'(m_out_valid), 32'd0);
    check("m_count", 32'(m_xfer_cnt), 32'd3);

    // back-to-back words, second with len 9 clamped to 8
    for (int i = 0; i < 8; i++) push(i == 7, 4'h1);
    for (int i = 0; i < 8; i++) push(i == 7, 4'h2);
    xfer_cnt = 0;
    offer(32'h11111111, 4'd0);
    offer(32'h22222222, 4'd9);
    drain(1'b0, cyc, low);
    check("t3_cycles", 32'(cyc), 32'd15);
    check("t3_ready_low", 32'(low), 32'd7);
    check("t3_count", 32'(xfer_cnt), 32'd16);

    // backpressure pattern 1,0,0
    for (int i = 0; i < 8; i++) push(i == 7, seq1[i]);
    xfer_cnt = 0;
    offer(32'habcd1234, 4'd0);
    drain(1'b1, cyc, low);
    check("t4_cycles", 32'(cyc), 32'd22);
    check("t4_count", 32'(xfer_cnt), 32'd8);

    // three words offered while the consumer stalls
    push(1'b0, 4'h1);
    push(1'b1, 4'h2);
    push(1'b1, 4'hf);
    push(1'b0, 4'h5);
    push(1'b1, 4'h5);
    xfer_cnt = 0;
    out_ready = 1'b0;
    offer(32'h87654321, 4'd2);
    offer(32'h0000000f, 4'd1);
    in_valid = 1'b1;
    in_data  = 32'h00000055;
    in_len   = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_blocked", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_before_retire", 32'(in_ready), 32'd0);
    offer(32'h00000055, 4'd2);
    drain(1'b0, cyc, low);
    check("t5_count", 32'(xfer_cnt), 32'd5);

    // reset mid-word with PENDING full
    push(1'b0, 4'h4);
    push(1'b0, 4'h3);
    push(1'b0, 4'h2);
    xfer_cnt = 0;
    offer(32'habcd1234, 4'd0);
    offer(32'h11111111, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd1);
    check("t6_rst_bits", 32'(out_bits), 32'd0);
    check("t6_pre_count", 32'(xfer_cnt), 32'd3);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_stale", 32'(out_valid), 32'd0);
    end
    push(1'b0, 4'h0);
    push(1'b1, 4'hf);
    xfer_cnt = 0;
    @(posedge clk);
    #1;
    offer(32'h9abcdef0, 4'd2);
    drain(1'b0, cyc, low);
    check("t6_cycles", 32'(cyc), 32'd2);
    check("t6_count", 32'(xfer_cnt), 32'd2);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunk_serializer.md
# chunk_serializer

Parametrised successor to the fixed 32-bit/4-bit chunk streamer: accepts full data words on a valid/ready input port and emits them as CHUNK_BITS-wide chunks on a valid/ready output port. Adds configurable chunk order, a per-word chunk count, end-of-word marking, output backpressure, and a one-word pending buffer so consecutive words stream without bubbles. It sits between word producers (sort engine result path) and narrow output pins or downstream chunk consumers.

## Interface
- CHUNK_BITS, 4, width of one output chunk
- NUM_CHUNKS, 8, chunks per full word; DATA_BITS = NUM_CHUNKS*CHUNK_BITS (derived, not overridable)
- MSB_FIRST, 0, 0: chunk 0 = bits [CHUNK_BITS-1:0] first; 1: most-significant chunk first
- LEN_BITS, $clog2(NUM_CHUNKS+1), derived width of in_len

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer offers a word
- in_ready  out  1  block can accept a word this cycle
- in_data  in  DATA_BITS  word to serialise
- in_len  in  LEN_BITS  chunks to emit from this word; 0 means NUM_CHUNKS; values > NUM_CHUNKS clamp to NUM_CHUNKS
- out_valid  out  1  out_bits holds a valid chunk
- out_ready  in  1  consumer takes the chunk this cycle
- out_bits  out  CHUNK_BITS  current chunk
- out_last  out  1  current chunk is the word's final chunk (qualified by out_valid)

## Operation
- Two word slots: ACTIVE (being emitted: data, length, chunk index) and PENDING (data, length). Each has a valid flag.
- in_ready = !pend_valid. Input transfer when in_valid && in_ready.
- Output transfer when out_valid && out_ready; index advances by 1. out_valid = act_valid.
- out_last = act_valid && (index == act_len-1).
- Chunk selection: LSB-first emits chunk k = in_data[k*CHUNK_BITS +: CHUNK_BITS], k = 0..len-1. MSB-first emits chunk NUM_CHUNKS-1-k, so with len<NUM_CHUNKS the top len chunks are sent.
- Word retire: output transfer while out_last. On retire, PENDING (if valid) moves into ACTIVE with index 0, else act_valid clears.
- Accepted word routing, same edge:
  - ACTIVE empty, or retiring this cycle with PENDING empty → goes directly to ACTIVE, index 0.
  - otherwise → PENDING.
- Retire and accept in the same cycle with PENDING full cannot occur (in_ready low). With PENDING full and retire: PENDING→ACTIVE, PENDING empties; in_ready rises next cycle.
- out_bits and out_last hold stable while out_valid && !out_ready.
- out_bits when !out_valid: don't-care, but drive 0.

## Timing
- Reset (reset_n low, async): act_valid=0, pend_valid=0, index=0 → out_valid=0, out_last=0, out_bits=0, in_ready=1. Inputs ignored while reset_n low. Assertion mid-word discards both slots immediately; no partial chunks after release.
- Latency: word accepted at edge N → first chunk valid after edge N (cycle N+1).
- Throughput: one chunk per cycle with out_ready held high, including across word boundaries (no idle cycle between last chunk of word A and first chunk of word B if B accepted before A retires).
- Single-chunk words (in_len=1): out_last asserted with the only chunk; back-to-back single-chunk words sustain 1 word/cycle.
- in_ready is a pure function of registered state (no combinational path from out_ready).

## Structure
- Package chunk_pkg: default CHUNK_BITS/NUM_CHUNKS constants, function computing LEN_BITS, length-normalising function (0/overflow → NUM_CHUNKS).
- Sub-module chunk_select: combinational chunk mux (data, index, MSB_FIRST) → chunk; reused by other chunk-stream blocks.
- Top holds the two slots, index counter, handshake logic; ~150-250 lines.

## Test plan
- Defaults, LSB-first, in_data=32'habcd1234, in_len=0, out_ready=1 → out_bits 4,3,2,1,d,c,b,a on 8 consecutive cycles, out_last only with a, then out_valid=0.
- MSB_FIRST=1, same word, in_len=3 → a,b,c; out_last with c; 3 cycles.
- Two words 32'h11111111 then 32'h22222222 offered back-to-back, out_ready=1 → 16 chunks with no gap; in_ready low for exactly the cycles PENDING is full.
- out_ready toggled 1,0,0,1,... during 32'habcd1234 → out_bits/out_last stable during stalls; sequence unchanged; total chunks = 8.
- Three words offered while out_ready=0 → first two accepted, in_ready=0 for third until first word retires.
- reset_n pulsed low after 3 chunks of a word with PENDING full → immediately out_valid=0, in_ready=1; after release no stale chunk appears; next word streams from chunk 0.
